// File: rtl/imm_extend_pkg.sv
// imm_extend_pkg
// Shared definitions for the pipelined immediate-extension stage:
//   - default immediate, output and tag widths
//   - extension-mode encoding (ZERO, SIGN, UPPER, BRANCH)
package imm_extend_pkg;

    localparam int IN_W_DEF  = 16;
    localparam int OUT_W_DEF = 32;
    localparam int TAG_W_DEF = 5;

    // Extension mode as carried on in_mode
    typedef enum logic [1:0] {
        MODE_ZERO   = 2'd0,
        MODE_SIGN   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } imm_mode_e;

endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core
// Purely combinational immediate extender.
// Parameters:
//   IN_W  - raw immediate width (>= 2)
//   OUT_W - extended width (>= IN_W + 2)
// Ports:
//   imm  in  IN_W   raw immediate
//   mode in  2      extension mode (see imm_extend_pkg)
//   data out OUT_W  extended immediate
//   neg  out 1      MSB of imm (sign hint)
module imm_extend_core
    import imm_extend_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data,
    output logic             neg
);

    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_ext_s;

    // Sign-extended form is shared by SIGN and BRANCH modes
    assign sign_ext_s = {{EXT_W{imm[IN_W-1]}}, imm};
    assign neg        = imm[IN_W-1];

    // Mode select; BRANCH drops the two top bits of the sign extension
    always_comb begin
        data = {OUT_W{1'b0}};
        case (mode)
            MODE_ZERO:   data = {{EXT_W{1'b0}}, imm};
            MODE_SIGN:   data = sign_ext_s;
            MODE_UPPER:  data = {imm, {EXT_W{1'b0}}};
            MODE_BRANCH: data = {sign_ext_s[OUT_W-3:0], 2'b00};
            default:     data = {OUT_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
// Pipelined immediate-extension stage between decode and execute.
// Entries are extended at the input (imm_extend_core) and registered, so an
// entry accepted on edge N is presented on out_* right after edge N.
// Optional build macro: IMM_EXTEND_PIPE_SKID_EN
//   defined   - one-entry skid register behind the output register, in_ready
//               is a flop equal to "skid empty", capacity 2
//   undefined - single output register, in_ready = !out_valid || out_ready,
//               capacity 1
// Ports:
//   Clk       in   1      clock, rising edge
//   Rst       in   1      asynchronous active-high reset
//   flush     in   1      synchronous flush, discards held and concurrent entries
//   in_valid  in   1      input entry present
//   in_ready  out  1      stage accepts an entry this cycle
//   in_imm    in   IN_W   raw immediate
//   in_mode   in   2      extension mode
//   in_tag    in   TAG_W  sideband tag
//   out_valid out  1      output entry present
//   out_ready in   1      downstream accepts the entry
//   out_data  out  OUT_W  extended immediate
//   out_tag   out  TAG_W  tag of the presented entry
//   out_neg   out  1      MSB of the presented entry's immediate
module imm_extend_pipe
    import imm_extend_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_neg
);

    logic [OUT_W-1:0] ext_data_s;
    logic             ext_neg_s;
    logic             in_ready_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    logic             out_valid_r;
    logic [OUT_W-1:0] out_data_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             out_neg_r;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .data (ext_data_s),
        .neg  (ext_neg_s)
    );

    assign in_xfer_s  = in_valid && in_ready_s;
    assign out_xfer_s = out_valid_r && out_ready;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_tag   = out_tag_r;
    assign out_neg   = out_neg_r;

`ifdef IMM_EXTEND_PIPE_SKID_EN

    logic             skid_valid_r;
    logic [OUT_W-1:0] skid_data_r;
    logic [TAG_W-1:0] skid_tag_r;
    logic             skid_neg_r;
    logic             in_ready_r;

    // in_ready is a flop that mirrors "skid empty"; no path from out_ready
    assign in_ready_s = in_ready_r;

    // Output register plus skid entry; skid only fills while the output stalls
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {OUT_W{1'b0}};
            out_tag_r    <= {TAG_W{1'b0}};
            out_neg_r    <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= {OUT_W{1'b0}};
            skid_tag_r   <= {TAG_W{1'b0}};
            skid_neg_r   <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (flush) begin
            // Concurrent input is dropped because nothing is loaded here
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (skid_valid_r) begin
            // Skid full implies in_ready low, so only draining can happen
            if (out_xfer_s) begin
                out_data_r   <= skid_data_r;
                out_tag_r    <= skid_tag_r;
                out_neg_r    <= skid_neg_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
                in_ready_r   <= 1'b1;
            end else begin
                in_ready_r   <= 1'b0;
            end
        end else if (in_xfer_s) begin
            if (!out_valid_r || out_ready) begin
                out_data_r   <= ext_data_s;
                out_tag_r    <= in_tag;
                out_neg_r    <= ext_neg_s;
                out_valid_r  <= 1'b1;
            end else begin
                skid_data_r  <= ext_data_s;
                skid_tag_r   <= in_tag;
                skid_neg_r   <= ext_neg_s;
                skid_valid_r <= 1'b1;
                in_ready_r   <= 1'b0;
            end
        end else if (out_xfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`else

    // Single register: accept when empty or when the held entry leaves now
    assign in_ready_s = !out_valid_r || out_ready;

    // Output register; reloads on a simultaneous drain and accept
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_tag_r   <= {TAG_W{1'b0}};
            out_neg_r   <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (in_xfer_s) begin
            out_data_r  <= ext_data_s;
            out_tag_r   <= in_tag;
            out_neg_r   <= ext_neg_s;
            out_valid_r <= 1'b1;
        end else if (out_xfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;
    import imm_extend_pkg::*;

    localparam int IW = 16;
    localparam int OW = 32;
    localparam int TW = 5;
`ifdef IMM_EXTEND_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_imm;
    logic [1:0]    in_mode;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          out_neg;

    logic          w8_in_valid;
    logic          w8_in_ready;
    logic [7:0]    w8_imm;
    logic [1:0]    w8_mode;
    logic [4:0]    w8_tag;
    logic          w8_out_valid;
    logic [15:0]   w8_out_data;
    logic [4:0]    w8_out_tag;
    logic          w8_out_neg;

    always #5 Clk = ~Clk;

    imm_extend_pipe #(.IN_W(IW), .OUT_W(OW), .TAG_W(TW)) dut (
        .Clk(Clk), .Rst(Rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_neg(out_neg)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut_w8 (
        .Clk(Clk), .Rst(Rst), .flush(1'b0),
        .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_imm(w8_imm),
        .in_mode(w8_mode), .in_tag(w8_tag),
        .out_valid(w8_out_valid), .out_ready(1'b1), .out_data(w8_out_data),
        .out_tag(w8_out_tag), .out_neg(w8_out_neg)
    );

    typedef struct {
        logic [OW-1:0] data;
        logic [TW-1:0] tag;
        logic          neg;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   rst_evt = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Extension by arithmetic on the numeric value of the immediate
    function automatic longint ref_ext(input int iw, input int ow, input longint imm, input int mode);
        longint full;
        longint sv;
        full = longint'(1) << ow;
        sv   = (imm >= (longint'(1) << (iw - 1))) ? imm - (longint'(1) << iw) : imm;
        if (mode == int'(MODE_ZERO))       return imm;
        else if (mode == int'(MODE_SIGN))  return (sv + full) % full;
        else if (mode == int'(MODE_UPPER)) return (imm * (longint'(1) << (ow - iw))) % full;
        else                               return (((sv * 4) % full) + full) % full;
    endfunction

    // Scoreboard: check on each falling edge, then advance the model to the next rising edge
    initial begin
        bit   exp_rdy;
        bit   take;
        ent_t e;
        forever begin
            @(negedge Clk);
            if (Rst || rst_evt) begin
                q.delete();
                rst_evt = 1'b0;
            end
            exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_data", out_data, q[0].data);
                chk("out_tag", out_tag, q[0].tag);
                chk("out_neg", out_neg, q[0].neg);
            end
            if (Rst) chk("rst_data", out_data, 0);
            if (!Rst && flush) begin
                q.delete();
            end else if (!Rst) begin
                take = in_valid && exp_rdy;
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (take) begin
                    e.data = OW'(ref_ext(IW, OW, longint'(in_imm), int'(in_mode)));
                    e.tag  = in_tag;
                    e.neg  = (in_imm >= (IW)'(1 << (IW - 1)));
                    q.push_back(e);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [IW-1:0] imm, input logic [1:0] m,
                        input logic [TW-1:0] t, input logic ordy, input logic fl);
        in_valid  = v;
        in_imm    = imm;
        in_mode   = m;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        @(posedge Clk);
        #1;
    endtask

    logic [15:0] w8_exp [4];
    logic [31:0] lit_exp [4];

    initial begin
        Rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = 2'd0;
        in_tag = '0; out_ready = 1'b1;
        w8_in_valid = 1'b0; w8_imm = 8'h00; w8_mode = 2'd0; w8_tag = 5'd0;
        lit_exp = '{32'h00008004, 32'hFFFF8004, 32'h80040000, 32'hFFFE0010};
        w8_exp  = '{16'h00F1, 16'hFFF1, 16'hF100, 16'hFFC4};
        #12 Rst = 1'b0;
        @(posedge Clk); #1;

        // Four modes on 16'h8004, tag 7, hand-computed values
        for (int m = 0; m < 4; m++) begin
            step(1'b1, 16'h8004, 2'(m), 5'd7, 1'b1, 1'b0);
            chk("lit_data", out_data, lit_exp[m]);
            chk("lit_tag", out_tag, 5'd7);
            chk("lit_neg", out_neg, 1'b1);
            chk("lit_valid", out_valid, 1'b1);
        end

        // Back-to-back stream of 8
        for (int i = 0; i < 8; i++)
            step(1'b1, 16'(i * 16'h1357 + 16'h0101), 2'(i % 4), 5'(i + 16), 1'b1, 1'b0);
        step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

        // Stall: out_ready low for 3 cycles with in_valid high
        for (int i = 0; i < 3; i++)
            step(1'b1, 16'hA000 + 16'(i), MODE_SIGN, 5'(10 + i), 1'b0, 1'b0);
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_data", out_data, 32'hFFFFA000);
        chk("stall_tag", out_tag, 5'd10);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

        // Flush with a concurrent input while full
        step(1'b1, 16'h1234, MODE_ZERO, 5'd1, 1'b0, 1'b0);
        step(1'b1, 16'h5678, MODE_ZERO, 5'd2, 1'b0, 1'b0);
        step(1'b1, 16'h9ABC, MODE_SIGN, 5'd3, 1'b0, 1'b1);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

        // Asynchronous reset pulse between edges during streaming
        step(1'b1, 16'h0F0F, MODE_UPPER, 5'd4, 1'b1, 1'b0);
        step(1'b1, 16'hF0F0, MODE_BRANCH, 5'd5, 1'b1, 1'b0);
        #1 Rst = 1'b1; rst_evt = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_data", out_data, 32'h0);
        chk("arst_tag", out_tag, 5'd0);
        chk("arst_neg", out_neg, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        #1 Rst = 1'b0;
        @(posedge Clk); #1;
        step(1'b1, 16'h7FFF, MODE_SIGN, 5'd6, 1'b1, 1'b0);
        chk("resume_data", out_data, 32'h00007FFF);
        step(1'b1, 16'h0001, MODE_BRANCH, 5'd8, 1'b1, 1'b0);
        chk("resume_branch", out_data, 32'h00000004);
        step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);

        // Width sweep on the 8-to-16 instance, imm 8'hF1
        for (int m = 0; m < 4; m++) begin
            w8_in_valid = 1'b1; w8_imm = 8'hF1; w8_mode = 2'(m); w8_tag = 5'(m);
            @(posedge Clk); #1;
            chk("w8_data", w8_out_data, w8_exp[m]);
            chk("w8_valid", w8_out_valid, 1'b1);
            chk("w8_neg", w8_out_neg, 1'b1);
        end
        w8_in_valid = 1'b0;
        @(posedge Clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
